// File: rtl/add_seq32_pkg.sv
// Shared ALU package: sequencer state encoding, default operand width and
// status-register bit positions for the multi-byte add/sub controller.
package add_seq32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NBYTES_DEFAULT = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/add_seq32_if.sv
// Operand-request and result handshakes of the multi-byte add/sub sequencer.
interface add_seq32_if #(
  parameter int NBYTES = 4
) ();
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         flag_z;
  logic         flag_n;
  logic         flag_v;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry, flag_z, flag_n, flag_v
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry, flag_z, flag_n, flag_v
  );
endinterface

// File: rtl/add_seq32_adder8.sv
// Existing 8-bit ripple adder of the ALU datapath, reused one byte per cycle.
module adder8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};

endmodule

// File: rtl/add_seq32.sv
// Byte-serial NBYTES-wide adder/subtractor around a single adder8.
// Z/N/V flags are generated only when ADD_SEQ_FLAGS_EN is defined.
module add_seq32
  import add_seq32_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  add_seq32_if.slave   bus
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e          state_q;
  logic [KW-1:0]   k_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [W-1:0]    res_q;
  logic [W-1:0]    res_d;
  logic [3:0]      status_q;
  logic [3:0]      status_d;

  logic [W-1:0]    a_q;
  logic [W-1:0]    beff_q;
  logic            sub_q;
  logic            carry_q;

  logic [7:0]      add_a;
  logic [7:0]      add_b;
  logic [7:0]      add_sum;
  logic            add_cin;
  logic            add_cout;
  logic            last_byte;

  adder8 u_adder8 (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Byte k of the operands feeds the adder; byte 0 takes sub as carry-in so
  // that A + ~B + 1 forms the two's-complement difference.
  always_comb begin
    add_a     = a_q[8*k_q +: 8];
    add_b     = beff_q[8*k_q +: 8];
    add_cin   = (k_q == '0) ? sub_q : carry_q;
    last_byte = (k_q == KW'(NBYTES - 1));

    res_d              = res_q;
    res_d[8*k_q +: 8]  = add_sum;

    status_d           = status_q;
    status_d[FLAG_C]   = add_cout;
`ifdef ADD_SEQ_FLAGS_EN
    status_d[FLAG_Z]   = (res_d == '0);
    status_d[FLAG_N]   = res_d[W-1];
    status_d[FLAG_V]   = (a_q[W-1] == beff_q[W-1]) && (res_d[W-1] != a_q[W-1]);
`else
    status_d[FLAG_Z]   = 1'b0;
    status_d[FLAG_N]   = 1'b0;
    status_d[FLAG_V]   = 1'b0;
`endif
  end

  // Operand capture and inter-byte carry; only meaningful while RUN.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && bus.in_valid) begin
      a_q    <= bus.a;
      beff_q <= bus.b ^ {W{bus.sub}};
      sub_q  <= bus.sub;
    end
    if (state_q == ST_RUN) begin
      carry_q <= add_cout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      status_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_q    <= ST_RUN;
            k_q        <= '0;
            in_ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          res_q <= res_d;
          if (last_byte) begin
            state_q     <= ST_DONE;
            k_q         <= '0;
            out_valid_q <= 1'b1;
            status_q    <= status_d;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          k_q         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.carry     = status_q[FLAG_C];
  assign bus.flag_z    = status_q[FLAG_Z];
  assign bus.flag_n    = status_q[FLAG_N];
  assign bus.flag_v    = status_q[FLAG_V];

endmodule

// File: tb/tb_add_seq32.sv
// Directed bench for add_seq32 (NBYTES=4); flag expectations follow ADD_SEQ_FLAGS_EN.
module tb_add_seq32;

`ifdef ADD_SEQ_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  add_seq32_if #(.NBYTES(4)) bus ();

  add_seq32 #(.NBYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d", total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, returns edges from accept to out_valid (capped at 20).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        output int lat);
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'h0) $display("FAIL rst_result got %h exp 0", bus.result); else pass_cnt++;
    total_cnt++; if (bus.carry !== 1'b0) $display("FAIL rst_carry got %b exp 0", bus.carry); else pass_cnt++;
    total_cnt++; if ({bus.flag_z, bus.flag_n, bus.flag_v} !== 3'b000)
      $display("FAIL rst_flags got %b exp 000", {bus.flag_z, bus.flag_n, bus.flag_v}); else pass_cnt++;
  endtask

  task automatic test_add();
    logic [31:0] va [3] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] vb [3] = '{32'h00000001, 32'h00000001, 32'h00000001};
    logic [31:0] vr [3] = '{32'h00000100, 32'h00000000, 32'h80000000};
    bit [3:0]    vf [3] = '{4'b0000, 4'b1100, 4'b0011}; // {C,Z,N,V}
    int lat;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL add%0d_in_ready got %b exp 1", i, bus.in_ready); else pass_cnt++;
      run_op(va[i], vb[i], 1'b0, lat);
      total_cnt++; if (lat !== 4) $display("FAIL add%0d_latency got %0d exp 4", i, lat); else pass_cnt++;
      total_cnt++; if (bus.result !== vr[i]) $display("FAIL add%0d_result got %h exp %h", i, bus.result, vr[i]); else pass_cnt++;
      total_cnt++; if (bus.carry !== vf[i][3]) $display("FAIL add%0d_carry got %b exp %b", i, bus.carry, vf[i][3]); else pass_cnt++;
      total_cnt++; if ({bus.flag_z, bus.flag_n, bus.flag_v} !== (vf[i][2:0] & {3{FE}}))
        $display("FAIL add%0d_flags got %b exp %b", i, {bus.flag_z, bus.flag_n, bus.flag_v}, vf[i][2:0] & {3{FE}});
      else pass_cnt++;
      release_result();
    end
  endtask

  task automatic test_sub();
    logic [31:0] va [2] = '{32'd5, 32'd7};
    logic [31:0] vb [2] = '{32'd7, 32'd5};
    logic [31:0] vr [2] = '{32'hFFFFFFFE, 32'h00000002};
    bit [3:0]    vf [2] = '{4'b0010, 4'b1000}; // {C,Z,N,V}
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(va[i], vb[i], 1'b1, lat);
      total_cnt++; if (lat !== 4) $display("FAIL sub%0d_latency got %0d exp 4", i, lat); else pass_cnt++;
      total_cnt++; if (bus.result !== vr[i]) $display("FAIL sub%0d_result got %h exp %h", i, bus.result, vr[i]); else pass_cnt++;
      total_cnt++; if (bus.carry !== vf[i][3]) $display("FAIL sub%0d_carry got %b exp %b", i, bus.carry, vf[i][3]); else pass_cnt++;
      total_cnt++; if ({bus.flag_z, bus.flag_n, bus.flag_v} !== (vf[i][2:0] & {3{FE}}))
        $display("FAIL sub%0d_flags got %b exp %b", i, {bus.flag_z, bus.flag_n, bus.flag_v}, vf[i][2:0] & {3{FE}});
      else pass_cnt++;
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(32'h000000FF, 32'h00000001, 1'b0, lat);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        bus.a = 32'hDEADBEEF; bus.b = 32'h01010101; bus.sub = 1'b1; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL bp%0d_out_valid got %b exp 1", c, bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp%0d_in_ready got %b exp 0", c, bus.in_ready); else pass_cnt++;
      total_cnt++; if (bus.result !== 32'h00000100) $display("FAIL bp%0d_result got %h exp 00000100", c, bus.result); else pass_cnt++;
      total_cnt++; if ({bus.carry, bus.flag_z, bus.flag_n, bus.flag_v} !== 4'b0000)
        $display("FAIL bp%0d_status got %b exp 0000", c, {bus.carry, bus.flag_z, bus.flag_n, bus.flag_v}); else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    release_result();
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_rel_in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_rel_out_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    tick();
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_idle_in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    run_op(32'h00000010, 32'h00000020, 1'b0, lat);
    total_cnt++; if (bus.result !== 32'h00000030) $display("FAIL b2b0_result got %h exp 00000030", bus.result); else pass_cnt++;
    tick();
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
    run_op(32'h00000100, 32'h00000001, 1'b1, lat);
    total_cnt++; if (lat !== 4) $display("FAIL b2b1_latency got %0d exp 4", lat); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'h000000FF) $display("FAIL b2b1_result got %h exp 000000FF", bus.result); else pass_cnt++;
    total_cnt++; if (bus.carry !== 1'b1) $display("FAIL b2b1_carry got %b exp 1", bus.carry); else pass_cnt++;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bus.a = 32'hFFFFFFFF; bus.b = 32'h00000001; bus.sub = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mid_out_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'h0) $display("FAIL mid_result got %h exp 0", bus.result); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL mid_in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.carry !== 1'b0) $display("FAIL mid_carry got %b exp 0", bus.carry); else pass_cnt++;
    run_op(32'h12345678, 32'h11111111, 1'b0, lat);
    total_cnt++; if (lat !== 4) $display("FAIL post_latency got %0d exp 4", lat); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'h23456789) $display("FAIL post_result got %h exp 23456789", bus.result); else pass_cnt++;
    total_cnt++; if ({bus.carry, bus.flag_z, bus.flag_n, bus.flag_v} !== 4'b0000)
      $display("FAIL post_status got %b exp 0000", {bus.carry, bus.flag_z, bus.flag_n, bus.flag_v}); else pass_cnt++;
    release_result();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
